// File: rtl/serial_subtractor_if.sv
// Start/busy/done operand and result bundle for serial_subtractor.
// Carries ovf only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf;

   modport master (
      output start, a, b,
      input  busy, done, diff, bout, ovf
   );
   modport slave (
      input  start, a, b,
      output busy, done, diff, bout, ovf
   );
`else
   modport master (
      output start, a, b,
      input  busy, done, diff, bout
   );
   modport slave (
      input  start, a, b,
      output busy, done, diff, bout
   );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b, one bit per clock.
// Optional SERIAL_SUB_OVF_EN adds a signed overflow flag (ovf).
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   serial_subtractor_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] sa, sb, dq;
   logic             borrow, bq;
   logic [CW-1:0]    cnt;
   logic             x, y, d, br_nx;

   assign x     = sa[0];
   assign y     = sb[0];
   assign d     = x ^ y ^ borrow;
   assign br_nx = (~x & y) | (~(x ^ y) & borrow);

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next state: accept in IDLE, exit RUN on the last bit, DONE is one cycle.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (bus.start) state_nx = RUN;
         RUN:     if (cnt == LAST) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign bus.busy = (state == RUN);
   assign bus.done = (state == DONE);
   assign bus.diff = dq;
   assign bus.bout = bq;

`ifdef SERIAL_SUB_OVF_EN
   logic oq;
   assign bus.ovf = oq;

   // Overflow: operand signs differ and the result sign differs from a.
   // On the last bit x/y are the operand MSBs and d is the result MSB.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         oq <= 1'b0;
      end else if (state == IDLE && bus.start) begin
         oq <= 1'b0;
      end else if (state == RUN && cnt == LAST) begin
         oq <= (x != y) && (d != x);
      end
   end
`endif

   // Datapath: load on accept, shift one bit per RUN cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sa     <= '0;
         sb     <= '0;
         dq     <= '0;
         borrow <= 1'b0;
         bq     <= 1'b0;
         cnt    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  sa     <= bus.a;
                  sb     <= bus.b;
                  dq     <= '0;
                  borrow <= 1'b0;
                  bq     <= 1'b0;
                  cnt    <= '0;
               end
            end
            RUN: begin
               sa     <= sa >> 1;
               sb     <= sb >> 1;
               dq     <= {d, dq[WIDTH-1:1]};
               borrow <= br_nx;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST) bq <= br_nx;
            end
            default: begin
            end
         endcase
      end
   end
endmodule
